// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the instruction fetch slice
// Contents: XLEN, NOP encoding, default reset PC, fetch FSM state enum,
//           buffered fetch entry {pc, instr}.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSN_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,  // request in flight, response will be kept
    WAIT_BUF = 2'd1,  // no request; buffer has no room for another response
    DRAIN    = 2'd2   // request in flight whose response is thrown away
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory, redirect and decode handshake bundle
// Signals: imem_req/imem_addr/imem_ready/imem_rdata (memory request/response),
//          redirect_valid/redirect_pc (control-flow change),
//          out_valid/out_pc/out_instr/out_ready (to decode).
// Modports: master = fetch controller, slave = memory/core environment.
interface fetch_ctrl_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid, out_pc, out_instr,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid, out_pc, out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - fetched-instruction FIFO with flush
// Ports: clk, reset_n (sync, active-low), flush (empties at the edge, wins
//        over push/pop), push/push_data, pop, head (combinational read of the
//        oldest entry), count (current occupancy).
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full buffer is accepted only when the head leaves this cycle.
  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FULL) || pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller: PC, request FSM, redirect handling
// Ports: clk, reset_n (sync, active-low), bus (fetch_ctrl_if.master: memory
//        request/response, redirect input, decode output handshake).
// Parameters: RESET_PC (first fetch address), BUF_DEPTH (2 or 4).
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          reset_n,
  fetch_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(BUF_DEPTH - 1);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic [XLEN-1:0] drain_addr, drain_addr_nxt;
  logic [XLEN-1:0] redirect_tgt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occ_after_pop;
  logic            out_valid;
  logic            pop;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_tgt  = bus.redirect_pc & ~32'h3;
  assign out_valid     = (count != '0);
  assign pop           = out_valid && bus.out_ready;
  assign occ_after_pop = count - {{(CNT_W-1){1'b0}}, pop};
  assign push_entry    = '{pc: fetch_pc, instr: bus.imem_rdata};

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // In DRAIN the abandoned request's address is held while fetch_pc already
  // carries the redirect target.
  assign bus.imem_req  = (state == FETCH) || (state == DRAIN);
  assign bus.imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;

  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? head.pc    : '0;
  assign bus.out_instr = out_valid ? head.instr : INSN_NOP;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    drain_addr_nxt = drain_addr;
    push           = 1'b0;
    case (state)
      FETCH: begin
        if (bus.redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
          if (!bus.imem_ready) begin
            state_nxt      = DRAIN;
            drain_addr_nxt = fetch_pc;
          end
        end else if (bus.imem_ready) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          // The entry just pushed takes a slot; another request needs one more.
          state_nxt    = (occ_after_pop < DEPTH_M1) ? FETCH : WAIT_BUF;
        end
      end
      WAIT_BUF: begin
        if (bus.redirect_valid) begin
          fetch_pc_nxt = redirect_tgt;
          state_nxt    = FETCH;
        end else if (occ_after_pop < DEPTH_C) begin
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (bus.redirect_valid) fetch_pc_nxt = redirect_tgt;
        // Buffer was flushed on entry and nothing is pushed here, so it has room.
        if (bus.imem_ready) state_nxt = FETCH;
      end
      default: state_nxt = WAIT_BUF;
    endcase
  end

  // Reset parks in WAIT_BUF with an empty buffer: no request during reset,
  // request at RESET_PC in the cycle after the first non-reset edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= WAIT_BUF;
      fetch_pc   <= RESET_PC;
      drain_addr <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      drain_addr <= drain_addr_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  import riscv_pkg::*;

  logic clk;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   pushes;
  logic [31:0] exp_pc;

  fetch_ctrl_if bus ();
  fetch_ctrl_if bus_w ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut_wrap (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_w)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  assign bus.imem_rdata   = mem_word(bus.imem_addr);
  assign bus_w.imem_rdata = mem_word(bus_w.imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n              = 1'b0;
    bus.imem_ready       = 1'b1;
    bus.out_ready        = 1'b1;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = '0;
    bus_w.imem_ready     = 1'b1;
    bus_w.out_ready      = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc    = '0;

    // Reset state
    tick();
    tick();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_instr", bus.out_instr, 32'h0000_0013);
    chk("rst_wrap_req", bus_w.imem_req, 0);

    // First request after release, then back-to-back stream
    reset_n = 1'b1;
    tick();
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, 32'h0);
    chk("first_addr_wrap", bus_w.imem_addr, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_valid", bus.out_valid, 1);
      chk("seq_pc", bus.out_pc, 32'(4 * i));
      chk("seq_instr", bus.out_instr, mem_word(32'(4 * i)));
      chk("wrap_pc", bus_w.out_pc, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Decode stalled from an empty buffer: exactly two pushes then idle
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bus.out_ready = 1'b0;
    pushes = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.imem_req && bus.imem_ready) pushes++;
      tick();
    end
    chk("stall_pushes", pushes, 2);
    chk("stall_req", bus.imem_req, 0);
    chk("stall_head", bus.out_pc, 32'h0);

    // Release: sequential PCs, no gap or repeat
    bus.out_ready = 1'b1;
    exp_pc = 32'h0;
    for (int k = 0; k < 20 && exp_pc != 32'h14; k++) begin
      if (bus.out_valid) begin
        chk("resume_pc", bus.out_pc, exp_pc);
        chk("resume_instr", bus.out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    chk("resume_done", exp_pc, 32'h14);

    // Fill buffer, then reset mid-stream
    bus.out_ready = 1'b0;
    for (int k = 0; k < 10 && bus.imem_req; k++) tick();
    chk("full_req_off", bus.imem_req, 0);
    chk("full_valid", bus.out_valid, 1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_req", bus.imem_req, 0);
    reset_n = 1'b1;
    tick();
    chk("restart_req", bus.imem_req, 1);
    chk("restart_addr", bus.imem_addr, 32'h0);

    // Slow memory, redirect during the wait: response drained, then target
    bus.imem_ready = 1'b0;
    bus.out_ready  = 1'b1;
    tick();
    chk("slow_addr", bus.imem_addr, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    chk("drain_req", bus.imem_req, 1);
    chk("drain_addr", bus.imem_addr, 32'h0);
    chk("drain_valid", bus.out_valid, 0);
    bus.imem_ready = 1'b1;
    tick();
    chk("tgt_req", bus.imem_req, 1);
    chk("tgt_addr", bus.imem_addr, 32'h100);
    chk("tgt_valid", bus.out_valid, 0);
    tick();
    chk("tgt_pc", bus.out_pc, 32'h100);
    chk("tgt_instr", bus.out_instr, mem_word(32'h100));

    // Redirect to unaligned target coincident with a response that would fill
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    tick();
    bus.redirect_valid = 1'b0;
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_req", bus.imem_req, 1);
    chk("flush_addr", bus.imem_addr, 32'h200);
    tick();
    chk("flush_pc", bus.out_pc, 32'h200);

    // Redirect while idle on a full buffer
    for (int k = 0; k < 10 && bus.imem_req; k++) tick();
    chk("wait_idle", bus.imem_req, 0);
    chk("wait_head", bus.out_pc, 32'h200);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    chk("wait_redir_req", bus.imem_req, 1);
    chk("wait_redir_addr", bus.imem_addr, 32'h300);
    chk("wait_redir_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
